// File: rtl/ram8_arbiter.sv
// Round-robin two-port access controller for the 8x16 RAM8 block.
// Zero-sweeps the whole RAM after reset or clr, then grants single-cycle reads/writes.
module ram8_arbiter #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             busy,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    output logic [WIDTH-1:0] ram_in,
    output logic [AW-1:0]    ram_address,
    output logic             ram_load,
    input  logic [WIDTH-1:0] ram_out
);

    typedef enum logic {SWEEP, ARB} state_t;

    localparam logic [AW-1:0] LAST_WORD = {AW{1'b1}};

    state_t          state_reg;
    logic [AW-1:0]   cnt_reg;
    logic            prio_reg;

    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0]       gnt;
    logic [AW-1:0]    addr  [2];
    logic [WIDTH-1:0] wdata [2];
    logic             sel_b;

    assign req      = {b_req, a_req};
    assign we       = {b_we, a_we};
    assign addr[0]  = a_addr;
    assign addr[1]  = b_addr;
    assign wdata[0] = a_wdata;
    assign wdata[1] = b_wdata;

    // B wins only when A is idle or it is B's turn; clr and the sweep block all grants.
    assign sel_b  = req[1] && (!req[0] || prio_reg);
    assign gnt[0] = (state_reg == ARB) && !clr && req[0] && !sel_b;
    assign gnt[1] = (state_reg == ARB) && !clr && sel_b;
    assign a_gnt  = gnt[0];
    assign b_gnt  = gnt[1];
    assign busy   = (state_reg == SWEEP);

    always_comb begin
        ram_address = '0;
        ram_in      = '0;
        ram_load    = 1'b0;
        if (state_reg == SWEEP) begin
            ram_address = cnt_reg;
            ram_load    = 1'b1;
        end else if (gnt[0]) begin
            ram_address = addr[0];
            ram_in      = wdata[0];
            ram_load    = we[0];
        end else if (gnt[1]) begin
            ram_address = addr[1];
            ram_in      = wdata[1];
            ram_load    = we[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SWEEP;
            cnt_reg   <= '0;
            prio_reg  <= 1'b0;
        end else begin
            case (state_reg)
                SWEEP: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_WORD) begin
                        state_reg <= ARB;
                    end
                end
                ARB: begin
                    if (clr) begin
                        state_reg <= SWEEP;
                        cnt_reg   <= '0;
                    end else if (gnt[0]) begin
                        prio_reg <= 1'b1;
                    end else if (gnt[1]) begin
                        prio_reg <= 1'b0;
                    end
                end
                default: state_reg <= SWEEP;
            endcase
        end
    end

    // Per-port read capture: ram_out is sampled on the granting edge.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : port_g
            logic             rvalid_reg;
            logic [WIDTH-1:0] rdata_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= gnt[gi] && !we[gi];
                    if (gnt[gi] && !we[gi]) begin
                        rdata_reg <= ram_out;
                    end
                end
            end
        end
    endgenerate

    assign a_rvalid = port_g[0].rvalid_reg;
    assign a_rdata  = port_g[0].rdata_reg;
    assign b_rvalid = port_g[1].rvalid_reg;
    assign b_rdata  = port_g[1].rdata_reg;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Self-checking bench for ram8_arbiter: a RAM8 stand-in plus a transaction-level
// reference model (memory image, turn holder, sweep countdown) checked every cycle.
module tb_ram8_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        busy;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [2:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [2:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [15:0] ram_in, ram_out;
    logic [2:0]  ram_address;
    logic        ram_load;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    int          sweep_left;
    logic        b_turn;
    logic [15:0] m_mem [8];
    logic        m_rv [2];
    logic [15:0] m_rd [2];

    // RAM8 stand-in
    logic [15:0] ram_mem [8];
    assign ram_out = ram_mem[ram_address];
    always @(posedge clk) begin
        if (ram_load) ram_mem[ram_address] <= ram_in;
    end

    ram8_arbiter #(.WIDTH(16), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (cyc %0d): got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance model at posedge,
    // then check registered outputs.
    task automatic cycle(input logic ar, input logic aw, input logic [2:0] aa, input logic [15:0] ad,
                         input logic br, input logic bw, input logic [2:0] ba, input logic [15:0] bd,
                         input logic c, output logic ga, output logic gb);
        logic        e_load;
        logic [2:0]  e_addr;
        logic [15:0] e_in;
        @(negedge clk);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        clr = c;
        #1;
        ga = 1'b0; gb = 1'b0; e_load = 1'b0; e_addr = 3'd0; e_in = 16'd0;
        if (sweep_left > 0) begin
            e_load = 1'b1;
            e_addr = 3'(8 - sweep_left);
        end else if (!c) begin
            if (ar && br) begin
                ga = !b_turn;
                gb = b_turn;
            end else begin
                ga = ar;
                gb = br;
            end
            if (ga) begin e_addr = aa; e_in = ad; e_load = aw; end
            if (gb) begin e_addr = ba; e_in = bd; e_load = bw; end
        end
        check("busy", busy, (sweep_left > 0));
        check("a_gnt", a_gnt, ga);
        check("b_gnt", b_gnt, gb);
        check("one_gnt", a_gnt & b_gnt, 0);
        check("ram_load", ram_load, e_load);
        check("ram_address", ram_address, e_addr);
        check("ram_in", ram_in, e_in);
        @(posedge clk);
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (sweep_left > 0) begin
            m_mem[8 - sweep_left] = 16'h0000;
            sweep_left--;
        end else if (c) begin
            sweep_left = 8;
            $display("cyc %0d: clr, sweep starts", cyc);
        end else begin
            if (ga) begin
                if (aw) m_mem[aa] = ad;
                else begin m_rv[0] = 1'b1; m_rd[0] = m_mem[aa]; end
                b_turn = 1'b1;
                $display("cyc %0d: A %s addr=%0d data=%04h", cyc, aw ? "wr" : "rd", aa, aw ? ad : m_mem[aa]);
            end
            if (gb) begin
                if (bw) m_mem[ba] = bd;
                else begin m_rv[1] = 1'b1; m_rd[1] = m_mem[ba]; end
                b_turn = 1'b0;
                $display("cyc %0d: B %s addr=%0d data=%04h", cyc, bw ? "wr" : "rd", ba, bw ? bd : m_mem[ba]);
            end
        end
        cyc++;
        #1;
        check("a_rvalid", a_rvalid, m_rv[0]);
        check("b_rvalid", b_rvalid, m_rv[1]);
        check("a_rdata", a_rdata, m_rd[0]);
        check("b_rdata", b_rdata, m_rd[1]);
    endtask

    // Asynchronous reset dropped between edges; effects must be visible immediately.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_ram_address", ram_address, 0);
        sweep_left = 8;
        b_turn = 1'b0;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = 16'h0; m_rd[1] = 16'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("cyc %0d: reset released", cyc);
    endtask

    task automatic idle(input int n);
        logic ga, gb;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    endtask

    initial begin
        logic ga, gb;
        logic        pa, pa_we, pb, pb_we, c;
        logic [2:0]  pa_addr, pb_addr;
        logic [15:0] pa_data, pb_data;
        logic [2:0]  ca, cb;

        rst_n = 1'b0; clr = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        for (int i = 0; i < 8; i++) begin
            ram_mem[i] = 16'hA5A0 + 16'(i);
            m_mem[i]   = 16'hA5A0 + 16'(i);
        end

        // Reset sweep, then read back all eight words through A
        do_reset();
        idle(8);
        for (int i = 0; i < 8; i++) cycle(1, 0, 3'(i), 0, 0, 0, 0, 0, 0, ga, gb);
        check("sweep_word7_read", a_rdata, 16'h0000);

        // Single-port write/read
        cycle(1, 1, 3'd1, 16'hFFFF, 0, 0, 0, 0, 0, ga, gb);
        cycle(1, 0, 3'd1, 16'h0000, 0, 0, 0, 0, 0, ga, gb);
        check("a_read_ffff", a_rdata, 16'hFFFF);

        // Hand the turn back to A, then contend for 6 cycles
        cycle(0, 0, 0, 0, 1, 0, 3'd0, 0, 0, ga, gb);
        ca = 3'd3; cb = 3'd5;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, ca, 16'h1000 + 16'(i), 1, 1, cb, 16'h2000 + 16'(i), 0, ga, gb);
            check("contend_a", ga, (i % 2 == 0));
            check("contend_b", gb, (i % 2 == 1));
            if (ga) ca = 3'(ca + 1);
            if (gb) cb = 3'(cb + 1);
        end

        // Cross-port coherence
        cycle(0, 0, 0, 0, 1, 1, 3'd2, 16'h00FF, 0, ga, gb);
        cycle(1, 0, 3'd2, 0, 0, 0, 0, 0, 0, ga, gb);
        check("cross_rdata", a_rdata, 16'h00FF);
        check("cross_b_rvalid", b_rvalid, 0);

        // Clear during traffic
        cycle(1, 1, 3'd4, 16'h0F0F, 0, 0, 0, 0, 0, ga, gb);
        cycle(1, 0, 3'd4, 0, 0, 0, 0, 0, 1, ga, gb);
        check("clr_no_gnt", ga, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 3'd4, 0, 0, 0, 0, 0, 0, ga, gb);
        cycle(1, 0, 3'd4, 0, 0, 0, 0, 0, 0, ga, gb);
        check("clr_read4", a_rdata, 16'h0000);

        // Async reset mid-sweep (cnt = 5) and in the cycle after a read grant
        cycle(1, 1, 3'd6, 16'hBEEF, 0, 0, 0, 0, 0, ga, gb);
        do_reset();
        idle(5);
        do_reset();
        idle(8);
        cycle(0, 0, 0, 0, 1, 1, 3'd6, 16'h1234, 0, ga, gb);
        cycle(0, 0, 0, 0, 1, 0, 3'd6, 0, 0, ga, gb);
        do_reset();
        idle(8);
        cycle(0, 0, 0, 0, 1, 0, 3'd6, 0, 0, ga, gb);
        check("post_reset_read6", b_rdata, 16'h0000);

        // Randomized traffic; requesters hold each transaction until granted
        pa = 0; pb = 0;
        pa_we = 0; pb_we = 0; pa_addr = 0; pb_addr = 0; pa_data = 0; pb_data = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1; pa_we = 1'($urandom_range(0, 1));
                pa_addr = 3'($urandom_range(0, 7)); pa_data = 16'($urandom);
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1; pb_we = 1'($urandom_range(0, 1));
                pb_addr = 3'($urandom_range(0, 7)); pb_data = 16'($urandom);
            end
            c = ($urandom_range(0, 39) == 0);
            cycle(pa, pa_we, pa_addr, pa_data, pb, pb_we, pb_addr, pb_data, c, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
